// File: rtl/bin2bcd.sv
// bin2bcd: sequential binary-to-BCD converter (double-dabble, one bit per cycle).
//
// Accepts one W-bit unsigned value through a valid/ready handshake. It shifts
// that value through a BCD accumulator for W cycles. It then presents the D-digit
// packed BCD result and its significant-digit count through a second
// valid/ready handshake.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst          synchronous active-high reset
//   in_valid     in_data holds a value to convert
//   in_ready     converter is idle and can take a value
//   in_data      W-bit unsigned binary input
//   out_valid    out_bcd / out_ndigits hold a finished result
//   out_ready    downstream accepts the result
//   out_bcd      packed BCD, digit 0 (units) in [3:0]
//   out_ndigits  number of significant decimal digits (1 for zero)
module bin2bcd #(
  parameter int W = 96,
  parameter int D = 29
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4*D-1:0]           out_bcd,
  output logic [$clog2(D+1)-1:0]   out_ndigits
);

  localparam int CW = $clog2(W + 1);
  localparam int NW = $clog2(D + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Per-digit correction ahead of the shift. Each digit >= 5 gets +3, so that
  // after doubling it carries cleanly into the next digit. No carry between digits.
  function automatic logic [4*D-1:0] add3_digits(input logic [4*D-1:0] acc);
    logic [4*D-1:0] r;
    r = '0;
    for (int i = 0; i < D; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = acc[4*i +: 4];
      end
    end
    return r;
  endfunction

  // One plus the index of the most-significant nonzero digit; a zero value
  // still reports one digit.
  function automatic logic [NW-1:0] count_digits(input logic [4*D-1:0] acc);
    logic [NW-1:0] n;
    n = NW'(1);
    for (int i = 0; i < D; i++) begin
      if (acc[4*i +: 4] != 4'd0) begin
        n = NW'(i + 1);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  logic [1:0]     state_q,       state_d;
  logic [W-1:0]   sr_q,          sr_d;
  logic [4*D-1:0] acc_q,         acc_d;
  logic [CW-1:0]  cnt_q,         cnt_d;
  logic           in_ready_q,    in_ready_d;
  logic           out_valid_q,   out_valid_d;
  logic [4*D-1:0] out_bcd_q,     out_bcd_d;
  logic [NW-1:0]  out_ndigits_q, out_ndigits_d;

  logic [4*D-1:0] acc_adj;
  logic [4*D-1:0] acc_shl;

  // Double-dabble datapath: correct digits, then shift in the next binary MSB.
  always_comb begin
    acc_adj = add3_digits(acc_q);
    acc_shl = (acc_adj << 1) | {{(4*D-1){1'b0}}, sr_q[W-1]};
  end

  // Next-state logic for the three-state controller and its datapath registers.
  always_comb begin
    state_d       = state_q;
    sr_d          = sr_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    in_ready_d    = in_ready_q;
    out_valid_d   = out_valid_q;
    out_bcd_d     = out_bcd_q;
    out_ndigits_d = out_ndigits_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d    = S_SHIFT;
          sr_d       = in_data;
          acc_d      = '0;
          cnt_d      = CW'(W);
          in_ready_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        acc_d = acc_shl;
        sr_d  = sr_q << 1;
        cnt_d = cnt_q - CW'(1);
        // Last bit shifts in on this edge: publish the result as DONE is entered.
        if (cnt_q == CW'(1)) begin
          state_d       = S_DONE;
          out_valid_d   = 1'b1;
          out_bcd_d     = acc_shl;
          out_ndigits_d = count_digits(acc_shl);
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_DONE: begin
        // Hand-off returns to IDLE; the next accept happens on a later edge.
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      sr_q          <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_bcd_q     <= '0;
      out_ndigits_q <= '0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_bcd_q     <= out_bcd_d;
      out_ndigits_q <= out_ndigits_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_bcd     = out_bcd_q;
  assign out_ndigits = out_ndigits_q;

endmodule

// File: doc/bin2bcd.md
BIN2BCD -- requirements
Module: bin2bcd

Interface
REQ-001 Parameter W, default 96: binary input width in bits.
REQ-002 Parameter D, default 29: number of BCD output digits; D SHALL satisfy 10^D > 2^W - 1.
REQ-003 clk  input  1  single clock; all state SHALL change only on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  in_data holds a value to convert.
REQ-006 in_ready  output  1  block can accept a new value.
REQ-007 in_data  input  W  unsigned binary value from the upstream generator.
REQ-008 out_valid  output  1  out_bcd and out_ndigits hold a finished result.
REQ-009 out_ready  input  1  downstream accepts the result.
REQ-010 out_bcd  output  4*D  packed BCD result; digit 0 (units) in bits [3:0], digit D-1 in the MSBs.
REQ-011 out_ndigits  output  $clog2(D+1)  count of significant decimal digits in the result.

Function
REQ-012 FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-013 in_ready SHALL be 1 in IDLE and 0 in SHIFT and DONE; out_valid SHALL be 1 only in DONE.
REQ-014 IDLE, edge with in_valid=1: capture in_data into a W-bit shift register, clear BCD accumulator, load bit counter with W, go to SHIFT; in_valid=0: stay.
REQ-015 SHIFT, each edge: every 4-bit accumulator digit >= 5 gets +3, then {accumulator, shift register} shifts left one bit, and the counter decrements (double-dabble).
REQ-016 After exactly W SHIFT edges, go to DONE; first out_valid=1 cycle follows edge W+1 counted from the accept edge.
REQ-017 On the transition into DONE: out_bcd = final accumulator; out_ndigits = 1 + index of the most-significant nonzero digit, or 1 if the value is 0.
REQ-018 out_bcd and out_ndigits SHALL be stable for as long as out_valid=1 and out_ready=0.
REQ-019 DONE, edge with out_ready=1: go to IDLE. out_bcd and out_ndigits keep their values until the next transition into DONE.
REQ-020 Accepting a new input and handing off a result SHALL never happen on the same edge. Throughput is one conversion per W+2 cycles when out_ready is held at 1.
REQ-021 in_valid asserted during SHIFT or DONE SHALL be ignored. Upstream holds in_valid/in_data until in_ready=1.
REQ-022 No digit SHALL exceed 9 at any time. Accumulator arithmetic is per-digit 4-bit, with no carry between digits before the shift.

Reset
REQ-023 On rst=1 at an edge: state=IDLE, out_valid=0, in_ready=1, out_bcd=0, out_ndigits=0, counter, shift register and accumulator = 0.
REQ-024 rst SHALL take priority over all other inputs in every state. A conversion in progress is discarded, and no out_valid pulse follows it.
REQ-025 The first edge after rst deasserts with in_valid=1 SHALL accept in_data.

Verification
REQ-026 Input 0, out_ready=1 -> after W+1 edges: out_bcd=0, out_ndigits=1, out_valid high for exactly one cycle.
REQ-027 Input 255 -> out_bcd[11:0]=0x255, upper bits 0, out_ndigits=3; in_ready low from the accept edge until the hand-off edge.
REQ-028 Input 2^96-1 -> out_bcd digits 79228162514264337593543950335, out_ndigits=29.
REQ-029 Input 354224848179261915075 (Fibonacci 100) with out_ready held 0 for 10 cycles -> result 354224848179261915075 with out_ndigits=21, held stable through the stall; IDLE is reached one edge after out_ready rises.
REQ-030 rst pulsed at SHIFT edge 40 of a conversion of 12345 -> out_valid stays 0 and all outputs read 0. A new input 42 applied next converts to 0x42 with out_ndigits=2.
REQ-031 Back-to-back stream of the first 100 Fibonacci values, in_valid always 1, out_ready random -> every result matches a reference decimal model, in order, with none dropped or duplicated.
